// File: rtl/riscv_ctrl_pkg.sv
// Shared constants and types for the decode-stage control block:
// opcodes, ALUOp encodings, ALU operation codes and the control bundle.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/riscv_decode_ctrl_adder_xlen.sv
// Plain XLEN-bit adder; carry-out is dropped so results wrap modulo 2^XLEN.
module adder_xlen #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/riscv_decode_ctrl.sv
// Decode-stage control: main decode, ALU control and PC adders, registered
// into ID/EX. Define DECODE_FLUSH_EN to add a flush input that bubbles control.
module riscv_decode_ctrl
  import riscv_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
`ifdef DECODE_FLUSH_EN
  input  logic            flush,
`endif
  input  logic [6:0]      opcode,
  input  logic [3:0]      funct,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic            branch,
  output logic            mem_read,
  output logic            mem_to_reg,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic [1:0]      alu_op,
  output logic [3:0]      operation,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] branch_target
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  ctrl_t           ctrl_p0;
  ctrl_t           ctrl_ld_p0;
  logic [3:0]      op_p0;
  logic [XLEN-1:0] imm_shl_p0;
  logic [XLEN-1:0] pc4_p0;
  logic [XLEN-1:0] bt_p0;

  ctrl_t           ctrl_p1;
  logic [3:0]      op_p1;
  logic [XLEN-1:0] pc4_p1;
  logic [XLEN-1:0] bt_p1;

  // Stage p0: combinational decode of the instruction in ID
  always_comb begin
    ctrl_p0 = '0;
    case (opcode)
      OP_RTYPE: begin
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_op    = ALUOP_FUNCT;
      end
      OP_ITYPE: begin
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.reg_write = 1'b1;
        ctrl_p0.alu_op    = ALUOP_ADD;
      end
      OP_LOAD: begin
        ctrl_p0.alu_src    = 1'b1;
        ctrl_p0.mem_to_reg = 1'b1;
        ctrl_p0.reg_write  = 1'b1;
        ctrl_p0.mem_read   = 1'b1;
        ctrl_p0.alu_op     = ALUOP_ADD;
      end
      OP_STORE: begin
        ctrl_p0.alu_src   = 1'b1;
        ctrl_p0.mem_write = 1'b1;
        ctrl_p0.alu_op    = ALUOP_ADD;
      end
      OP_BRANCH: begin
        ctrl_p0.branch = 1'b1;
        ctrl_p0.alu_op = ALUOP_SUB;
      end
      default: ctrl_p0 = '0;
    endcase
  end

  // ALU control follows the freshly decoded ALUOp, not the registered copy
  always_comb begin
    op_p0 = ALU_ADD;
    case (ctrl_p0.alu_op)
      ALUOP_ADD: op_p0 = ALU_ADD;
      ALUOP_SUB: op_p0 = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          4'b0000: op_p0 = ALU_ADD;
          4'b1000: op_p0 = ALU_SUB;
          4'b0111: op_p0 = ALU_AND;
          4'b0110: op_p0 = ALU_OR;
          4'b0100: op_p0 = ALU_XOR;
          4'b0001: op_p0 = ALU_SLL;
          4'b0101: op_p0 = ALU_SRL;
          default: op_p0 = ALU_ADD;
        endcase
      end
      default: op_p0 = ALU_ADD;
    endcase
  end

`ifdef DECODE_FLUSH_EN
  assign ctrl_ld_p0 = flush ? '0 : ctrl_p0;
`else
  assign ctrl_ld_p0 = ctrl_p0;
`endif

  assign imm_shl_p0 = imm << 1;

  adder_xlen #(.XLEN(XLEN)) u_pc_plus4 (
    .a   (pc),
    .b   (PC_STEP),
    .sum (pc4_p0)
  );

  adder_xlen #(.XLEN(XLEN)) u_branch_target (
    .a   (pc),
    .b   (imm_shl_p0),
    .sum (bt_p0)
  );

  // Stage p1: ID/EX boundary registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_p1 <= '0;
      op_p1   <= '0;
      pc4_p1  <= '0;
      bt_p1   <= '0;
    end else begin
      ctrl_p1 <= ctrl_ld_p0;
      op_p1   <= op_p0;
      pc4_p1  <= pc4_p0;
      bt_p1   <= bt_p0;
    end
  end

  assign alu_src       = ctrl_p1.alu_src;
  assign mem_to_reg    = ctrl_p1.mem_to_reg;
  assign reg_write     = ctrl_p1.reg_write;
  assign mem_read      = ctrl_p1.mem_read;
  assign mem_write     = ctrl_p1.mem_write;
  assign branch        = ctrl_p1.branch;
  assign alu_op        = ctrl_p1.alu_op;
  assign operation     = op_p1;
  assign pc_plus4      = pc4_p1;
  assign branch_target = bt_p1;

endmodule

// File: tb/tb_riscv_decode_ctrl.sv
// Scoreboard bench for riscv_decode_ctrl; flush vectors are added when
// DECODE_FLUSH_EN is defined.
module tb_riscv_decode_ctrl;

  localparam int XLEN = 64;

  logic            clk;
  logic            reset;
  logic            flush;
  logic [6:0]      opcode;
  logic [3:0]      funct;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] imm;
  logic            branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write;
  logic [1:0]      alu_op;
  logic [3:0]      operation;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] branch_target;

  riscv_decode_ctrl #(.XLEN(XLEN)) dut (
    .clk           (clk),
    .reset         (reset),
`ifdef DECODE_FLUSH_EN
    .flush         (flush),
`endif
    .opcode        (opcode),
    .funct         (funct),
    .pc            (pc),
    .imm           (imm),
    .branch        (branch),
    .mem_read      (mem_read),
    .mem_to_reg    (mem_to_reg),
    .mem_write     (mem_write),
    .alu_src       (alu_src),
    .reg_write     (reg_write),
    .alu_op        (alu_op),
    .operation     (operation),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string           name;
    logic [7:0]      ctrl;
    logic [3:0]      op;
    logic [XLEN-1:0] p4;
    logic [XLEN-1:0] bt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // ctrl packing: {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op}
  localparam logic [7:0] C_R   = 8'b0010_0010;
  localparam logic [7:0] C_I   = 8'b1010_0000;
  localparam logic [7:0] C_LD  = 8'b1111_0000;
  localparam logic [7:0] C_ST  = 8'b1000_1000;
  localparam logic [7:0] C_BR  = 8'b0000_0101;
  localparam logic [7:0] C_NOP = 8'b0000_0000;

  function automatic logic [7:0] act_ctrl();
    return {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op};
  endfunction

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ctrl"}, {56'd0, act_ctrl()}, '0);
    chk({nm, ".operation"}, {60'd0, operation}, '0);
    chk({nm, ".pc_plus4"}, pc_plus4, '0);
    chk({nm, ".branch_target"}, branch_target, '0);
  endtask

  // Monitor: every output cycle with a pending expectation gets compared
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.name, ".ctrl"}, {56'd0, act_ctrl()}, {56'd0, e.ctrl});
      chk({e.name, ".operation"}, {60'd0, operation}, {60'd0, e.op});
      chk({e.name, ".pc_plus4"}, pc_plus4, e.p4);
      chk({e.name, ".branch_target"}, branch_target, e.bt);
    end
  end

  task automatic apply(input string nm, input logic fl, input logic [6:0] opc,
                       input logic [3:0] fn, input logic [XLEN-1:0] p,
                       input logic [XLEN-1:0] im, input logic [7:0] ec,
                       input logic [3:0] eop, input logic [XLEN-1:0] ep4,
                       input logic [XLEN-1:0] ebt);
    exp_t e;
    @(negedge clk);
    flush  = fl;
    opcode = opc;
    funct  = fn;
    pc     = p;
    imm    = im;
    @(posedge clk);
    e.name = nm; e.ctrl = ec; e.op = eop; e.p4 = ep4; e.bt = ebt;
    sb.push_back(e);
  endtask

  initial begin
    reset  = 1'b1;
    flush  = 1'b0;
    opcode = 7'b0110011;
    funct  = 4'b0000;
    pc     = 64'h100;
    imm    = '0;
    #1 reset = 1'b0;
    #2 chk_all_zero("reset_async");

    @(negedge clk);
    reset = 1'b1;
    apply("rel_rtype", 0, 7'b0110011, 4'b0000, 64'h100, 64'h0, C_R, 4'b0010, 64'h104, 64'h100);

    apply("r_sub", 0, 7'b0110011, 4'b1000, 64'h200, 64'h10, C_R, 4'b0110, 64'h204, 64'h220);
    apply("r_and", 0, 7'b0110011, 4'b0111, 64'h0,   64'h0,  C_R, 4'b0000, 64'h4,   64'h0);
    apply("r_or",  0, 7'b0110011, 4'b0110, 64'h8,   64'h1,  C_R, 4'b0001, 64'hC,   64'hA);
    apply("r_dflt",0, 7'b0110011, 4'b0011, 64'h10,  64'h2,  C_R, 4'b0010, 64'h14,  64'h14);
    apply("r_xor", 0, 7'b0110011, 4'b0100, 64'h20,  64'h0,  C_R, 4'b0100, 64'h24,  64'h20);
    apply("r_sll", 0, 7'b0110011, 4'b0001, 64'h20,  64'h0,  C_R, 4'b0011, 64'h24,  64'h20);
    apply("r_srl", 0, 7'b0110011, 4'b0101, 64'h20,  64'h0,  C_R, 4'b0101, 64'h24,  64'h20);
    apply("i_add", 0, 7'b0010011, 4'b1000, 64'h30,  64'h4,  C_I, 4'b0010, 64'h34,  64'h38);
    apply("load",  0, 7'b0000011, 4'b0111, 64'h1000, 64'h8, C_LD, 4'b0010, 64'h1004, 64'h1010);
    apply("store", 0, 7'b0100011, 4'b0010, 64'h2000, 64'h0, C_ST, 4'b0010, 64'h2004, 64'h2000);
    apply("branch",0, 7'b1100011, 4'b0000, 64'h40, 64'hFFFF_FFFF_FFFF_FFF8, C_BR, 4'b0110, 64'h44, 64'h30);
    apply("wrap",  0, 7'b0010011, 4'b0000, 64'hFFFF_FFFF_FFFF_FFFC, 64'h8000_0000_0000_0001,
          C_I, 4'b0010, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE);
    apply("illegal", 0, 7'b1111111, 4'b1000, 64'h50, 64'h0, C_NOP, 4'b0010, 64'h54, 64'h50);
    apply("zero_op", 0, 7'b0000000, 4'b0111, 64'h60, 64'h0, C_NOP, 4'b0010, 64'h64, 64'h60);
`ifdef DECODE_FLUSH_EN
    apply("flush_load", 1, 7'b0000011, 4'b0000, 64'h70, 64'h4, C_NOP, 4'b0010, 64'h74, 64'h78);
    apply("after_flush", 0, 7'b0000011, 4'b0000, 64'h80, 64'h0, C_LD, 4'b0010, 64'h84, 64'h80);
    apply("flush_br", 1, 7'b1100011, 4'b0000, 64'h90, 64'h0, C_NOP, 4'b0110, 64'h94, 64'h90);
`endif

    begin
      int budget = 20;
      while (sb.size() > 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      n_checks++;
      if (sb.size() == 0) n_pass++;
      else $display("FAIL drain: %0d expectations left, expected 0", sb.size());
    end

    // Asynchronous reset mid-run, with flush raised alongside it
    @(negedge clk);
    opcode = 7'b0000011;
    pc     = 64'h300;
    flush  = 1'b1;
    #2 reset = 1'b0;
    #1 chk_all_zero("reset_mid");
    @(posedge clk);
    #1 chk_all_zero("reset_hold");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
